// File: rtl/uart_debug_host.sv
// UART-driven debug bus initiator: 8N1 RX/TX, command parser and single-word request issue.
// 'R' A0..A3 -> D0..D3, 'W' A0..A3 D0..D3 -> 0x06, anything else -> 0x15.
module uart_debug_host #(
    parameter int unsigned CLKS_PER_BIT   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        rxd,
    output logic        txd,
    output logic        amif_read,
    output logic        amif_write,
    output logic [31:0] amif_addr,
    output logic [31:0] amif_store,
    input  logic [31:0] amif_load,
    input  logic        amif_ready,
    output logic        busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] BitMax  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfMax = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TmoW-1:0] TmoMax  = TmoW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] OpRead  = 8'h52;
    localparam logic [7:0] OpWrite = 8'h57;
    localparam logic [7:0] RspAck  = 8'h06;
    localparam logic [7:0] RspNak  = 8'h15;

    // ---------------------------------------------------------------- UART receiver
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    rx_state_e       rx_state_q;
    logic            rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [CntW-1:0] rx_cnt_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_byte_q;
    logic            rx_valid_q, rx_err_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_state_q <= RxIdle;
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            unique case (rx_state_q)
                RxIdle: begin
                    if (rxd_prev_q && !rxd_sync_q) begin
                        rx_state_q <= RxStart;
                        rx_cnt_q   <= '0;
                    end
                end
                RxStart: begin
                    if (rx_cnt_q == HalfMax) begin
                        // A start that is no longer low at mid-bit was a glitch
                        rx_state_q <= rxd_sync_q ? RxIdle : RxData;
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RxData: begin
                    if (rx_cnt_q == BitMax) begin
                        rx_cnt_q  <= '0;
                        rx_byte_q <= {rxd_sync_q, rx_byte_q[7:1]};
                        rx_bit_q  <= rx_bit_q + 1'b1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RxStop: begin
                    if (rx_cnt_q == BitMax) begin
                        rx_valid_q <= rxd_sync_q;
                        rx_err_q   <= !rxd_sync_q;
                        rx_state_q <= RxIdle;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    // ---------------------------------------------------------------- UART transmitter
    logic            tx_busy_q;
    logic [8:0]      tx_shift_q;
    logic [3:0]      tx_bit_q;
    logic [CntW-1:0] tx_cnt_q;
    logic            tx_valid, tx_ready, tx_fire;
    logic [7:0]      tx_data;

    // Accepting during the last stop-bit cycle keeps consecutive frames back-to-back
    assign tx_ready = !tx_busy_q || (tx_bit_q == 4'd9 && tx_cnt_q == BitMax);
    assign tx_fire  = tx_valid && tx_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tx_busy_q  <= 1'b0;
            tx_shift_q <= '1;
            tx_bit_q   <= '0;
            tx_cnt_q   <= '0;
            txd        <= 1'b1;
        end else if (tx_fire) begin
            tx_busy_q  <= 1'b1;
            tx_shift_q <= {1'b1, tx_data};
            tx_bit_q   <= '0;
            tx_cnt_q   <= '0;
            txd        <= 1'b0;
        end else if (tx_busy_q) begin
            if (tx_cnt_q == BitMax) begin
                tx_cnt_q <= '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                end else begin
                    txd        <= tx_shift_q[0];
                    tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                    tx_bit_q   <= tx_bit_q + 1'b1;
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- command parser
    typedef enum logic [2:0] {StIdle, StAddr, StData, StReq, StResp} state_e;

    state_e          state_q;
    logic            is_write_q;
    logic            nak_q;
    logic [1:0]      byte_cnt_q;
    logic [1:0]      resp_idx_q;
    logic [31:0]     rd_data_q;
    logic [TmoW-1:0] tmo_cnt_q;
    logic            collecting, tmo_hit;

    assign collecting = (state_q == StAddr) || (state_q == StData);
    assign tmo_hit    = collecting && (tmo_cnt_q == TmoMax);

    // A pending NAK takes the transmitter ahead of any command response
    always_comb begin
        tx_valid = nak_q || (state_q == StResp);
        if (nak_q) begin
            tx_data = RspNak;
        end else if (is_write_q) begin
            tx_data = RspAck;
        end else begin
            tx_data = rd_data_q[{resp_idx_q, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= StIdle;
            is_write_q <= 1'b0;
            nak_q      <= 1'b0;
            byte_cnt_q <= '0;
            resp_idx_q <= '0;
            rd_data_q  <= '0;
            tmo_cnt_q  <= '0;
            amif_read  <= 1'b0;
            amif_write <= 1'b0;
            amif_addr  <= '0;
            amif_store <= '0;
            busy       <= 1'b0;
        end else begin
            if (rx_valid_q || !collecting) begin
                tmo_cnt_q <= '0;
            end else if (!tmo_hit) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (tx_fire && nak_q) nak_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (rx_valid_q) begin
                        if (rx_byte_q == OpRead || rx_byte_q == OpWrite) begin
                            is_write_q <= (rx_byte_q == OpWrite);
                            byte_cnt_q <= '0;
                            busy       <= 1'b1;
                            state_q    <= StAddr;
                        end else begin
                            nak_q <= 1'b1;
                        end
                    end
                end
                StAddr, StData: begin
                    if (rx_err_q || (tmo_hit && !rx_valid_q)) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else if (rx_valid_q) begin
                        if (state_q == StAddr) amif_addr  <= {rx_byte_q, amif_addr[31:8]};
                        else                   amif_store <= {rx_byte_q, amif_store[31:8]};
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        if (byte_cnt_q == 2'd3) begin
                            state_q <= (state_q == StAddr && is_write_q) ? StData : StReq;
                        end
                    end
                end
                StReq: begin
                    if (!amif_read && !amif_write) begin
                        amif_read  <= !is_write_q;
                        amif_write <= is_write_q;
                    end else if (amif_ready) begin
                        amif_read  <= 1'b0;
                        amif_write <= 1'b0;
                        if (!is_write_q) rd_data_q <= amif_load;
                        resp_idx_q <= '0;
                        state_q    <= StResp;
                    end
                end
                StResp: begin
                    if (tx_fire && !nak_q) begin
                        if (is_write_q || resp_idx_q == 2'd3) begin
                            busy    <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            resp_idx_q <= resp_idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_debug_host.sv
// Directed bench for uart_debug_host: serial commands in, bus requests and serial responses checked.
module tb_uart_debug_host;

    localparam int unsigned CPB = 4;
    localparam int unsigned TMO = 200;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        rxd = 1'b1;
    logic        txd;
    logic        amif_read, amif_write, busy;
    logic [31:0] amif_addr, amif_store;
    logic [31:0] amif_load = '0;
    logic        amif_ready = 1'b0;

    uart_debug_host #(
        .CLKS_PER_BIT  (CPB),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .rxd       (rxd),
        .txd       (txd),
        .amif_read (amif_read),
        .amif_write(amif_write),
        .amif_addr (amif_addr),
        .amif_store(amif_store),
        .amif_load (amif_load),
        .amif_ready(amif_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    logic [7:0] tx_q[$];
    int tx_t[$];
    int tx_frame_err = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;
    int both_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Serial decoder on txd: records each byte and the cycle its start bit began
    initial begin : tx_mon
        logic       prev;
        logic [7:0] b;
        int         t0;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !txd) begin
                t0 = cyc;
                repeat (CPB / 2) @(negedge clk);
                if (txd !== 1'b0) tx_frame_err++;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = txd;
                end
                repeat (CPB) @(negedge clk);
                if (txd !== 1'b1) tx_frame_err++;
                tx_q.push_back(b);
                tx_t.push_back(t0);
            end
            prev = txd;
        end
    end

    initial begin : bus_mon
        logic rp, wp;
        rp = 1'b0;
        wp = 1'b0;
        forever begin
            @(negedge clk);
            if (amif_read && !rp) rd_pulses++;
            if (amif_write && !wp) wr_pulses++;
            if (amif_read && amif_write) both_cnt++;
            rp = amif_read;
            wp = amif_write;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = ~bad_stop;
        tick(CPB);
        rxd = 1'b1;
        tick(2);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0);
    endtask

    task automatic wait_req(input bit wr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (wr ? amif_write : amif_read) ok = 1'b1;
        end
    endtask

    task automatic wait_tx(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (tx_q.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic pulse_ready(input logic [31:0] load);
        @(posedge clk);
        #1;
        amif_load  = load;
        amif_ready = 1'b1;
        tick(1);
        amif_ready = 1'b0;
        amif_load  = '0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int delay);
        int n0, w0, r0;
        bit ok, held;
        n0 = tx_q.size();
        w0 = wr_pulses;
        r0 = rd_pulses;
        send_byte(8'h57, 1'b0);
        send_word(addr);
        send_word(data);
        wait_req(1'b1, ok);
        chk("wr_req_seen", {31'd0, ok}, 1);
        chk("wr_addr", amif_addr, addr);
        chk("wr_store", amif_store, data);
        held = 1'b1;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            if (!amif_write || amif_read || amif_addr !== addr || amif_store !== data) held = 1'b0;
        end
        @(posedge clk);
        #1;
        amif_ready = 1'b1;
        if (!amif_write) held = 1'b0;
        tick(1);
        amif_ready = 1'b0;
        chk("wr_held_until_ready", {31'd0, held}, 1);
        chk("wr_drop_after_ready", {31'd0, amif_write}, 0);
        wait_tx(n0 + 1, ok);
        chk("wr_ack_seen", {31'd0, ok}, 1);
        if (ok) chk("wr_ack_byte", {24'd0, tx_q[n0]}, 32'h06);
        chk("wr_pulse_count", wr_pulses - w0, 1);
        chk("wr_no_read", rd_pulses - r0, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] load, input int delay);
        int n0, w0, r0;
        bit ok, gaps_ok;
        n0 = tx_q.size();
        w0 = wr_pulses;
        r0 = rd_pulses;
        send_byte(8'h52, 1'b0);
        send_word(addr);
        wait_req(1'b0, ok);
        chk("rd_req_seen", {31'd0, ok}, 1);
        chk("rd_addr", amif_addr, addr);
        tick(delay);
        chk("rd_still_held", {31'd0, amif_read}, 1);
        pulse_ready(load);
        chk("rd_drop_after_ready", {31'd0, amif_read}, 0);
        wait_tx(n0 + 4, ok);
        chk("rd_resp_seen", {31'd0, ok}, 1);
        if (ok) begin
            gaps_ok = 1'b1;
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rd_resp_byte%0d", i), {24'd0, tx_q[n0+i]}, {24'd0, load[8*i +: 8]});
                if (i > 0 && tx_t[n0+i] - tx_t[n0+i-1] != 10 * CPB) gaps_ok = 1'b0;
            end
            chk("rd_back_to_back", {31'd0, gaps_ok}, 1);
        end
        chk("rd_busy_clear", {31'd0, busy}, 0);
        chk("rd_pulse_count", rd_pulses - r0, 1);
        chk("rd_no_write", wr_pulses - w0, 0);
    endtask

    initial begin : main
        int n0, r0, w0;
        bit ok;

        // Reset state
        tick(3);
        chk("rst_txd", {31'd0, txd}, 1);
        chk("rst_read", {31'd0, amif_read}, 0);
        chk("rst_write", {31'd0, amif_write}, 0);
        chk("rst_addr", amif_addr, 0);
        chk("rst_store", amif_store, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        nrst = 1'b1;

        ok = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (txd !== 1'b1 || amif_read !== 1'b0 || amif_write !== 1'b0 || busy !== 1'b0)
                ok = 1'b0;
        end
        chk("idle_quiet_1000", {31'd0, ok}, 1);

        do_write(32'h2000_0000, 32'hDEAD_BEEF, 5);
        do_read(32'h0000_0004, 32'h1234_5678, 3);

        // Unknown opcode
        n0 = tx_q.size();
        r0 = rd_pulses;
        w0 = wr_pulses;
        send_byte(8'hAA, 1'b0);
        wait_tx(n0 + 1, ok);
        chk("nak_seen", {31'd0, ok}, 1);
        if (ok) chk("nak_byte", {24'd0, tx_q[n0]}, 32'h15);
        tick(20);
        chk("nak_no_bus", (rd_pulses - r0) + (wr_pulses - w0), 0);
        chk("nak_busy", {31'd0, busy}, 0);

        // Framing error on the first address byte
        n0 = tx_q.size();
        r0 = rd_pulses;
        send_byte(8'h52, 1'b0);
        send_byte(8'h08, 1'b1);
        tick(100);
        chk("frame_busy", {31'd0, busy}, 0);
        chk("frame_no_resp", tx_q.size() - n0, 0);
        chk("frame_no_req", rd_pulses - r0, 0);
        do_read(32'h0000_0008, 32'hCAFE_F00D, 1);

        // Inter-byte timeout discards the partial write
        w0 = wr_pulses;
        send_byte(8'h57, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        tick(250);
        chk("tmo_busy", {31'd0, busy}, 0);
        do_read(32'h0000_0000, 32'hA5A5_0F0F, 2);
        chk("tmo_no_write", wr_pulses - w0, 0);

        // Reset while the request is outstanding
        send_byte(8'h52, 1'b0);
        send_word(32'h0000_0010);
        wait_req(1'b0, ok);
        chk("rstreq_req_seen", {31'd0, ok}, 1);
        tick(3);
        nrst = 1'b0;
        #1;
        chk("rstreq_read_drop", {31'd0, amif_read}, 0);
        chk("rstreq_busy", {31'd0, busy}, 0);
        tick(2);
        nrst = 1'b1;
        n0 = tx_q.size();
        tick(100);
        chk("rstreq_no_resp", tx_q.size() - n0, 0);
        do_write(32'h0000_0040, 32'h55AA_55AA, 2);

        chk("never_rd_and_wr", both_cnt, 0);
        chk("tx_frame_errors", tx_frame_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_debug_host.md
Name: uart_debug_host

Overview:
- Off-chip debug initiator that converts a byte-oriented UART command stream into single-word bus requests.
- Drives the controller side of the debug AXI controller interface: the AXI debug controller in the system top is the responder; this block is the requester.
- Integrates its own 8N1 UART receiver and transmitter, a command parser FSM and an inter-byte timeout for resynchronisation.
- Sits outside the system top, between the host serial link and the top's debug interface port.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit (>=4)
TIMEOUT_CYCLES, 1000000, idle clk cycles between command bytes before the parser aborts to IDLE

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
rxd  input  1  serial in from host, asynchronous, idle high
txd  output  1  serial out to host, idle high
amif_read  output  1  read request, held until amif_ready
amif_write  output  1  write request, held until amif_ready
amif_addr  output  32  request byte address
amif_store  output  32  write data
amif_load  input  32  read data, valid in the amif_ready cycle
amif_ready  input  1  one-cycle completion strobe from responder
busy  output  1  high whenever parser is not in IDLE

Behaviour:
- Reset:
  - Clock is clk; reset is nrst, asynchronous assert, active-low.
  - All registers clear.
  - txd=1, amif_read=0, amif_write=0, amif_addr=0, amif_store=0, busy=0.
  - Parser enters IDLE; RX and TX go idle.
  - Reset mid-frame or mid-request drops everything; no response is sent.
- UART RX (8N1, LSB first):
  - rxd is synchronised through 2 flops.
  - Start is detected on a falling edge and confirmed low at CLKS_PER_BIT/2.
  - Each data bit is sampled every CLKS_PER_BIT thereafter; the stop bit is sampled the same way.
  - Stop=0 is a framing error: the byte is discarded and the parser aborts to IDLE without response.
  - Good byte produces a 1-cycle rx_valid to the parser.
- UART TX (8N1):
  - Accepts a byte only when idle.
  - Sends 1 start bit, 8 data bits LSB first, then 1 stop bit, each CLKS_PER_BIT cycles.
  - A byte accepted in the same cycle the previous stop bit ends follows back-to-back.
- Command protocol (multi-byte fields little-endian):
  - 0x52 'R', A0..A3: read; response is D0..D3.
  - 0x57 'W', A0..A3, D0..D3: write; response is 0x06.
  - Any other opcode in IDLE: respond 0x15, stay IDLE.
- Parser states:
  - IDLE -> ADDR on a valid opcode.
  - ADDR: collect 4 bytes into amif_addr. Exits to REQ for 'R', DATA for 'W'.
  - DATA: collect 4 bytes into amif_store, then -> REQ.
  - REQ: assert amif_read or amif_write the cycle after entry. Hold it, with addr/store stable, until amif_ready=1.
    - Read: latch amif_load in that cycle.
    - Request deasserts the next cycle; -> RESP.
  - RESP: queue response bytes to TX, one per TX-idle, then -> IDLE after the last byte is accepted.
- Bus handshake rules:
  - Never both read and write asserted.
  - amif_ready outside REQ is ignored.
  - No timeout in REQ (responder guaranteed to complete).
- Timeout:
  - A counter resets on every received byte and counts only in ADDR/DATA.
  - Reaching TIMEOUT_CYCLES -> IDLE silently; partial fields are discarded.
- Bytes received during REQ/RESP are dropped (host must wait for the response).
- busy=1 in ADDR, DATA, REQ, RESP.

Test Plan:
- Reset idle: nrst low then high, no rxd activity -> txd=1, amif_read=amif_write=0, busy=0 for 1000 cycles.
- Write (CLKS_PER_BIT=4): send 57 00 00 00 20 EF BE AD DE.
  - Required: amif_write=1, amif_addr=0x20000000, amif_store=0xDEADBEEF, held across a 5-cycle ready delay; deasserts the cycle after amif_ready.
  - Required: txd carries 0x06.
- Read: send 52 04 00 00 00; responder returns amif_load=0x12345678 with amif_ready after 3 cycles.
  - Required: amif_read=1, amif_addr=0x00000004.
  - Required: txd sends 78 56 34 12 back-to-back, busy returns to 0 after the final stop bit.
- Bad opcode and framing error:
  - Send 0xAA -> txd 0x15, no bus activity.
  - Send 52 with a corrupted stop bit on its second byte -> no request issued, no response, parser back in IDLE; a following valid read succeeds.
- Timeout (TIMEOUT_CYCLES=200): send 57 00 11, then wait 250 cycles, then send 52 00 00 00 00.
  - Required: a read at addr 0 only, with no write issued.
- Reset mid-request: hold amif_ready=0 in REQ, pulse nrst.
  - Required: amif_read drops immediately, no txd activity, next command works.
